// File: rtl/status_register_unit.sv
// 6502 processor status register P (NV-BDIZC) with a one-op-deep ALU flag writeback pipeline.
// Optional macro STATUS_CMOS_DCLR_EN: interrupt entry also clears D (65C02 behaviour).
module status_register_unit #(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_start,
    input  logic [3:0] alu_op,
    input  logic [7:0] alu_psr,
    input  logic       flag_cmd_valid,
    input  logic [2:0] flag_cmd,
    input  logic       bit_valid,
    input  logic [7:0] bit_mem,
    input  logic [7:0] bit_acc,
    input  logic       plp_valid,
    input  logic [7:0] plp_data,
    input  logic       irq_entry,
    input  logic       push_req,
    input  logic       push_brk,
    output logic [7:0] p_out,
    output logic       carry_out,
    output logic       decimal_out,
    output logic       irq_mask,
    output logic [7:0] push_data,
    output logic       push_valid,
    output logic       wb_pending
);

    logic [3:0] pend_op;
    logic [7:0] pend_mask;
    logic [7:0] p_next;

    // Flags each ALU op class may legitimately change (N=7, V=6, Z=1, C=0).
    function automatic logic [7:0] op_mask(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001:                            op_mask = 8'hC3;
            4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111: op_mask = 8'h82;
            4'b0101, 4'b1000, 4'b1001, 4'b1010, 4'b1011: op_mask = 8'h83;
            default:                                     op_mask = 8'h00;
        endcase
    endfunction

    assign pend_mask   = op_mask(pend_op);
    assign carry_out   = (wb_pending && pend_mask[0]) ? alu_psr[0] : p_out[0];
    assign decimal_out = p_out[3];

    // Writers applied lowest priority first so later ones override per flag.
    always_comb begin
        p_next = p_out;
        if (flag_cmd_valid) begin
            case (flag_cmd)
                3'b000:  p_next[0] = 1'b0;
                3'b001:  p_next[0] = 1'b1;
                3'b010:  p_next[2] = 1'b0;
                3'b011:  p_next[2] = 1'b1;
                3'b100:  p_next[3] = 1'b0;
                3'b101:  p_next[3] = 1'b1;
                3'b110:  p_next[6] = 1'b0;
                default: ;
            endcase
        end
        if (bit_valid) begin
            p_next[7] = bit_mem[7];
            p_next[6] = bit_mem[6];
            p_next[1] = ((bit_acc & bit_mem) == 8'h00);
        end
        if (wb_pending)
            p_next = (p_next & ~pend_mask) | (alu_psr & pend_mask);
        if (irq_entry) begin
            p_next[2] = 1'b1;
`ifdef STATUS_CMOS_DCLR_EN
            p_next[3] = 1'b0;
`else
`endif
        end
        if (plp_valid)
            p_next = plp_data;
        p_next[5] = 1'b1;
        p_next[4] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_out      <= RESET_P;
            pend_op    <= 4'h0;
            wb_pending <= 1'b0;
            irq_mask   <= 1'b1;
            push_valid <= 1'b0;
            push_data  <= 8'h00;
        end else begin
            p_out      <= p_next;
            pend_op    <= alu_op;
            wb_pending <= alu_start;
            // Interrupt logic sees I one cycle late, except entry masks immediately.
            irq_mask   <= irq_entry | p_out[2];
            push_valid <= push_req;
            if (push_req)
                push_data <= {p_next[7:6], 1'b1, push_brk, p_next[3:0]};
        end
    end

endmodule

// File: doc/status_register_unit.md
Name: status_register_unit

Overview:
- Holds the 6502 processor status register P (NV-BDIZC) and consumes the per-op flag byte the ALU produces.
- Applies only the flags each ALU op legitimately affects, one cycle after the op is issued.
- Also services flag instructions (CLC/SEC/CLI/SEI/CLD/SED/CLV), BIT, PLP, PHP/BRK/IRQ pushes and interrupt entry.
- Feeds the carry and decimal inputs back to the ALU and provides the interrupt mask to the interrupt controller.

Parameters:
- RESET_P, 8'h24, P value after reset (I=1, bit5=1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_start  in  1  ALU op issued this cycle (ALU samples same edge)
- alu_op  in  4  ALU op code issued with alu_start
- alu_psr  in  8  ALU flag output, valid the cycle after alu_start
- flag_cmd_valid  in  1  flag instruction strobe
- flag_cmd  in  3  000 CLC, 001 SEC, 010 CLI, 011 SEI, 100 CLD, 101 SED, 110 CLV, 111 no-op
- bit_valid  in  1  BIT instruction strobe
- bit_mem  in  8  memory operand for BIT
- bit_acc  in  8  accumulator for BIT
- plp_valid  in  1  load P from stack byte
- plp_data  in  8  pulled byte
- irq_entry  in  1  interrupt/BRK entry: set I
- push_req  in  1  request status byte for stack push
- push_brk  in  1  B value for pushed byte (1 = PHP/BRK, 0 = IRQ/NMI)
- p_out  out  8  current P; bit5 always 1, bit4 always 0
- carry_out  out  1  carry to ALU (forwarded)
- decimal_out  out  1  D to ALU
- irq_mask  out  1  I as seen by interrupt logic (delayed)
- push_data  out  8  status byte for stack
- push_valid  out  1  one-cycle pulse, push_data valid
- wb_pending  out  1  ALU writeback outstanding this cycle

Behaviour:
- Reset (async):
  - P = RESET_P, irq_mask = 1.
  - push_valid = 0, push_data = 0, wb_pending = 0, pending op cleared.
- ALU writeback pipeline:
  - alu_start at cycle T latches alu_op into the pending register; wb_pending = 1 during T+1.
  - The edge ending T+1 merges alu_psr into P under the op mask:
    - 0000/0001 ADC/SBC: N,V,Z,C.
    - 0010/0011/0100 AND/OR/XOR: N,Z.
    - 0101 CMP: N,Z,C.
    - 0110/0111 INC/DEC: N,Z.
    - 1000-1011 shifts/rotates: N,Z,C.
    - 1100-1111: no flags.
  - D, I, B, bit5 are never taken from alu_psr.
  - Back-to-back alu_start every cycle is legal; each op writes back exactly once, in order.
- carry_out = alu_psr[0] when wb_pending and the pending mask includes C, otherwise P.C. This supports multi-byte ADC/SBC chains without a bubble.
- decimal_out = P.D (registered, no forwarding).
- flag_cmd: sets or clears the single named flag at the edge.
- BIT: N = bit_mem[7], V = bit_mem[6], Z = ((bit_acc & bit_mem) == 0).
- PLP: P = plp_data with bit5 forced to 1 and bit4 forced to 0.
- irq_entry: I = 1 at the edge; irq_mask = 1 at the same edge.
- irq_mask otherwise follows P.I one cycle late. CLI/SEI/PLP change P.I at edge E and irq_mask at E+1.
- Same-edge merge, per flag, lowest to highest priority: flag_cmd < bit < ALU writeback < irq_entry < plp. The highest-priority writer of each individual flag wins; untouched flags hold.
- Push:
  - push_req at cycle T produces push_valid = 1 during T+1.
  - push_data = {N,V,1,push_brk,D,I,Z,C} taken from the P value that results from the edge ending T, including any writeback applied at that edge.
  - push_valid is high for exactly one cycle per push_req; consecutive push_req cycles give consecutive pulses.
- Reset mid-operation: any pending writeback and any push_valid are discarded, with no late update after rst deasserts.

Optional Feature:
- Macro: STATUS_CMOS_DCLR_EN.
- Defined: irq_entry also clears D at the same edge (65C02 behaviour). plp still overrides D if simultaneous.
- Undefined: irq_entry leaves D unchanged (NMOS behaviour).

Test Plan:
- Reset, then release -> p_out = 8'h24, irq_mask = 1, push_valid = 0, wb_pending = 0.
- alu_start with op 0000 at T, alu_psr = 8'hC3 at T+1 -> p_out = 8'hE7 after the T+1 edge (N,V,Z,C set; D unchanged; I stays 1). Same sequence with op 0010 -> only N,Z updated, giving 8'hA6.
- Two ADC ops on consecutive cycles, first alu_psr[0] = 1 with P.C = 0 -> carry_out = 1 during the first writeback cycle (forwarded); both writebacks land in order.
- CLI at edge E with P = 8'h24 -> p_out = 8'h20 after E, irq_mask still 1 until E+1. irq_entry together with CLI -> I = 1, irq_mask = 1.
- P = 8'h21, push_req with push_brk = 1 -> push_valid pulses one cycle with push_data = 8'h31. push_brk = 0 -> push_data = 8'h21.
- plp_data = 8'hFF with simultaneous SEC and a pending ALU writeback -> p_out = 8'hEF. With STATUS_CMOS_DCLR_EN defined, irq_entry on P = 8'h2C -> p_out = 8'h24 (D cleared); undefined -> 8'h2C.
